// File: rtl/pcie_rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// pcie_rst_seq_pkg
//   Shared types and elaboration helpers for the PCIe reset sequencer.
//   - seq_state_t : sequencer FSM states
//   - cnt_width   : width of the shared cycle counter
//   - retry_width : width of the retry counter
//   - idx_width   : width of the channel index used during staggered release
// ---------------------------------------------------------------------------
package pcie_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_RELEASE,
        ST_WAIT_LINK,
        ST_DONE,
        ST_FAIL
    } seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Wide enough to hold the largest of the hold, stagger and timeout limits.
    function automatic int cnt_width(input int hold, input int stagger, input int timeout);
        int w;
        w = $clog2(max3(hold, stagger, timeout) + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // MAX_RETRY = 0 would give a zero-width vector; keep at least one bit.
    function automatic int retry_width(input int max_retry);
        int w;
        w = $clog2(max_retry + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int idx_width(input int num_ch);
        int w;
        w = $clog2(num_ch);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pcie_rst_seq_if.sv
// ---------------------------------------------------------------------------
// pcie_rst_seq_if
//   Control/status bundle between a reset source (master) and the reset
//   sequencer (slave).
//   start      master->slave  1-cycle pulse to begin a reset sequence
//   link_up    master->slave  per-channel link-up, asynchronous to sys_clk
//   ch_rst_n   slave->master  per-channel active-low reset
//   busy       slave->master  sequence in progress
//   done       slave->master  all links up, sequence complete
//   fail       slave->master  retries exhausted, cores held in reset
//   retry_cnt  slave->master  retries consumed in the current sequence
// ---------------------------------------------------------------------------
interface pcie_rst_seq_if #(
    parameter int NUM_CH  = 2,
    parameter int RETRY_W = 2
) ();

    logic                start;
    logic [NUM_CH-1:0]   link_up;
    logic [NUM_CH-1:0]   ch_rst_n;
    logic                busy;
    logic                done;
    logic                fail;
    logic [RETRY_W-1:0]  retry_cnt;

    modport master (
        output start, link_up,
        input  ch_rst_n, busy, done, fail, retry_cnt
    );

    modport slave (
        input  start, link_up,
        output ch_rst_n, busy, done, fail, retry_cnt
    );

endinterface

// File: rtl/pcie_rst_seq_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Single-bit two-flop synchroniser with asynchronous active-low reset to 0.
//   sys_clk    in   destination clock
//   sys_rst_n  in   async active-low reset
//   d          in   asynchronous input
//   q          out  synchronised output, two sys_clk cycles of latency
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pcie_rst_seq.sv
// ---------------------------------------------------------------------------
// pcie_rst_seq
//   Parametrised reset sequencer for PCIe bring-up tops. Holds NUM_CH
//   active-low channel resets for HOLD_CYCLES, releases them staggered by
//   STAGGER_CYCLES, then watches the synchronised link_up bits. A missing or
//   lost link triggers a re-reset, up to MAX_RETRY times, after which the
//   cores are parked in reset and fail is raised.
//   sys_clk    in   sequencer clock
//   sys_rst_n  in   async active-low reset, aborts any sequence at once
//   bus        slave modport of pcie_rst_seq_if (start, link_up, ch_rst_n,
//                   busy, done, fail, retry_cnt)
// ---------------------------------------------------------------------------
module pcie_rst_seq
    import pcie_rst_seq_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int HOLD_CYCLES    = 10,
    parameter int STAGGER_CYCLES = 4,
    parameter int LINKUP_TIMEOUT = 4096,
    parameter int MAX_RETRY      = 3
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    pcie_rst_seq_if.slave bus
);

    localparam int CNT_W   = cnt_width(HOLD_CYCLES, STAGGER_CYCLES, LINKUP_TIMEOUT);
    localparam int RETRY_W = retry_width(MAX_RETRY);
    localparam int IDX_W   = idx_width(NUM_CH);

    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LINKUP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX      = '1;
    localparam logic [IDX_W-1:0]   IDX_LAST     = IDX_W'(NUM_CH - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    if (NUM_CH < 1) begin : g_chk_num_ch
        $fatal(1, "pcie_rst_seq: NUM_CH must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_chk_hold
        $fatal(1, "pcie_rst_seq: HOLD_CYCLES must be >= 1");
    end
    if (STAGGER_CYCLES < 1) begin : g_chk_stagger
        $fatal(1, "pcie_rst_seq: STAGGER_CYCLES must be >= 1");
    end
    if (LINKUP_TIMEOUT < 1) begin : g_chk_timeout
        $fatal(1, "pcie_rst_seq: LINKUP_TIMEOUT must be >= 1");
    end
    if (MAX_RETRY < 0) begin : g_chk_retry
        $fatal(1, "pcie_rst_seq: MAX_RETRY must be >= 0");
    end

    seq_state_t         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   ch_idx, ch_idx_nxt;
    logic [NUM_CH-1:0]  rel, rel_nxt;
    logic [RETRY_W-1:0] retry, retry_nxt;
    logic [NUM_CH-1:0]  link_sync;
    logic               all_up;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
        sync_2ff u_sync (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .d         (bus.link_up[i]),
            .q         (link_sync[i])
        );
    end

    assign all_up = &link_sync;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            ch_idx <= '0;
            rel    <= '0;
            retry  <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ch_idx <= ch_idx_nxt;
            rel    <= rel_nxt;
            retry  <= retry_nxt;
        end
    end

    // The shared counter means "hold cycles" in ASSERT, "cycles since the
    // previous channel release" in RELEASE and "cycles since the last release"
    // in WAIT_LINK; it is cleared on every state entry that uses it.
    // Channel release happens when the stagger counter is at 0, so with
    // STAGGER_CYCLES=1 the index advances on every cycle.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        ch_idx_nxt = ch_idx;
        rel_nxt    = rel;
        retry_nxt  = retry;

        case (state)
            ST_IDLE: begin
                rel_nxt = '0;
                if (bus.start) begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end
            end

            ST_ASSERT: begin
                rel_nxt    = '0;
                ch_idx_nxt = '0;
                if (cnt == HOLD_LAST) begin
                    state_nxt = ST_RELEASE;
                    cnt_nxt   = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (cnt == '0) begin
                    rel_nxt[ch_idx] = 1'b1;
                end
                if (cnt == '0 && ch_idx == IDX_LAST) begin
                    state_nxt = ST_WAIT_LINK;
                    cnt_nxt   = '0;
                end else if (cnt == STAGGER_LAST) begin
                    cnt_nxt    = '0;
                    ch_idx_nxt = ch_idx + 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            // Success is tested before the timeout so a link that comes up on
            // the timeout cycle still completes the sequence.
            ST_WAIT_LINK: begin
                if (all_up) begin
                    state_nxt = ST_DONE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry < RETRY_LIMIT) begin
                        retry_nxt = retry + 1'b1;
                        state_nxt = ST_ASSERT;
                        cnt_nxt   = '0;
                        rel_nxt   = '0;
                    end else begin
                        state_nxt = ST_FAIL;
                        rel_nxt   = '0;
                    end
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            // A link lost after completion is handled like a timeout.
            ST_DONE: begin
                if (bus.start) begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                    rel_nxt   = '0;
                end else if (!all_up) begin
                    if (retry < RETRY_LIMIT) begin
                        retry_nxt = retry + 1'b1;
                        state_nxt = ST_ASSERT;
                        cnt_nxt   = '0;
                        rel_nxt   = '0;
                    end else begin
                        state_nxt = ST_FAIL;
                        rel_nxt   = '0;
                    end
                end
            end

            ST_FAIL: begin
                rel_nxt = '0;
                if (bus.start) begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                rel_nxt   = '0;
            end
        endcase
    end

    assign bus.ch_rst_n  = rel;
    assign bus.busy      = (state == ST_ASSERT) || (state == ST_RELEASE) || (state == ST_WAIT_LINK);
    assign bus.done      = (state == ST_DONE);
    assign bus.fail      = (state == ST_FAIL);
    assign bus.retry_cnt = retry;

endmodule

// File: tb/tb_pcie_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_pcie_rst_seq
//   Two sequencers: dut_a (2 channels, stagger 4, timeout 16, 3 retries) and
//   dut_b (4 channels, stagger 1, timeout 16). Expected output values are
//   queued with the cycle on which they must appear and compared on the
//   falling edge after that rising edge.
// ---------------------------------------------------------------------------
module tb_pcie_rst_seq;

    localparam int SIG_A_CH    = 0;
    localparam int SIG_A_BUSY  = 1;
    localparam int SIG_A_DONE  = 2;
    localparam int SIG_A_FAIL  = 3;
    localparam int SIG_A_RETRY = 4;
    localparam int SIG_B_CH    = 5;
    localparam int SIG_B_BUSY  = 6;
    localparam int SIG_B_DONE  = 7;
    localparam int SIG_B_RETRY = 8;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       tag;
    } exp_t;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    int   cyc       = 0;
    int   total_cnt = 0;
    int   bad_cnt   = 0;
    exp_t sb[$];

    pcie_rst_seq_if #(.NUM_CH(2), .RETRY_W(2)) bus_a ();
    pcie_rst_seq_if #(.NUM_CH(4), .RETRY_W(2)) bus_b ();

    pcie_rst_seq #(
        .NUM_CH(2), .HOLD_CYCLES(10), .STAGGER_CYCLES(4),
        .LINKUP_TIMEOUT(16), .MAX_RETRY(3)
    ) dut_a (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus_a)
    );

    pcie_rst_seq #(
        .NUM_CH(4), .HOLD_CYCLES(10), .STAGGER_CYCLES(1),
        .LINKUP_TIMEOUT(16), .MAX_RETRY(3)
    ) dut_b (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus_b)
    );

    always #5 sys_clk = ~sys_clk;

    // Rising-edge counter; on a falling edge it names the edge just taken.
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            SIG_A_CH:    return 32'(bus_a.ch_rst_n);
            SIG_A_BUSY:  return 32'(bus_a.busy);
            SIG_A_DONE:  return 32'(bus_a.done);
            SIG_A_FAIL:  return 32'(bus_a.fail);
            SIG_A_RETRY: return 32'(bus_a.retry_cnt);
            SIG_B_CH:    return 32'(bus_b.ch_rst_n);
            SIG_B_BUSY:  return 32'(bus_b.busy);
            SIG_B_DONE:  return 32'(bus_b.done);
            SIG_B_RETRY: return 32'(bus_b.retry_cnt);
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Keeps the queue ordered by cycle; cycle -1 means "check right now".
    task automatic sb_push(input int c, input int sig, input logic [31:0] v, input string tag);
        exp_t e;
        int   pos;
        e.cyc = c;
        e.sig = sig;
        e.val = v;
        e.tag = tag;
        pos = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > c) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, e);
    endtask

    task automatic drain_now();
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < 0) begin
            e = sb.pop_front();
            checkOutput(e.tag, observe(e.sig), e.val);
        end
    endtask

    // Pops every expectation due on the edge just taken.
    always @(negedge sys_clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc >= 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checkOutput(e.tag, observe(e.sig), e.val);
        end
    end

    task automatic wait_edge(input int n);
        while (cyc < n) @(negedge sys_clk);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) @(negedge sys_clk);
        if (sb.size() > 0) begin
            checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Pulses start so that it is sampled on rising edge t; returns at the
    // falling edge after t.
    task automatic applyStimulus(input int which, input int t);
        wait_edge(t - 1);
        if (which == 0) bus_a.start = 1'b1;
        else            bus_b.start = 1'b1;
        @(negedge sys_clk);
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n     = 1'b0;
        bus_a.start   = 1'b0;
        bus_b.start   = 1'b0;
        bus_a.link_up = '0;
        bus_b.link_up = '0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        int b;
        int d;

        bus_a.start   = 1'b0;
        bus_b.start   = 1'b0;
        bus_a.link_up = '0;
        bus_b.link_up = '0;

        // Reset values while sys_rst_n is low.
        #2;
        sb_push(-1, SIG_A_CH,    0, "rst_a_ch");
        sb_push(-1, SIG_A_BUSY,  0, "rst_a_busy");
        sb_push(-1, SIG_A_DONE,  0, "rst_a_done");
        sb_push(-1, SIG_A_FAIL,  0, "rst_a_fail");
        sb_push(-1, SIG_A_RETRY, 0, "rst_a_retry");
        sb_push(-1, SIG_B_CH,    0, "rst_b_ch");
        drain_now();
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Single successful sequence on dut_a.
        t = cyc + 2;
        applyStimulus(0, t);
        sb_push(t + 1,  SIG_A_BUSY,  1, "t1_busy");
        sb_push(t + 1,  SIG_A_CH,    0, "t1_hold");
        sb_push(t + 10, SIG_A_CH,    0, "t1_hold_end");
        sb_push(t + 11, SIG_A_CH,    1, "t1_rel0");
        sb_push(t + 14, SIG_A_CH,    1, "t1_stagger");
        sb_push(t + 15, SIG_A_CH,    3, "t1_rel1");
        sb_push(t + 26, SIG_A_DONE,  0, "t1_not_done");
        sb_push(t + 27, SIG_A_DONE,  1, "t1_done");
        sb_push(t + 27, SIG_A_BUSY,  0, "t1_idle_busy");
        sb_push(t + 27, SIG_A_RETRY, 0, "t1_retry");
        wait_edge(t + 24);
        bus_a.link_up = 2'b11;
        wait_drain(200);

        // Async reset during release, then start pulses while busy.
        do_reset();
        t = cyc + 2;
        applyStimulus(0, t);
        sb_push(t + 10, SIG_A_CH,   0, "t4_hold_end");
        sb_push(t + 10, SIG_A_BUSY, 1, "t4_busy");
        sb_push(t + 11, SIG_A_CH,   1, "t4_rel0");
        sb_push(t + 12, SIG_A_CH,   1, "t4_rel0_hold");
        wait_edge(t + 12);
        #1;
        sys_rst_n = 1'b0;
        #1;
        sb_push(-1, SIG_A_CH,    0, "t4_abort_ch");
        sb_push(-1, SIG_A_BUSY,  0, "t4_abort_busy");
        sb_push(-1, SIG_A_RETRY, 0, "t4_abort_retry");
        drain_now();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        sb_push(cyc + 2, SIG_A_CH,   0, "t4_idle_ch");
        sb_push(cyc + 2, SIG_A_BUSY, 0, "t4_idle_busy");
        wait_drain(50);

        t = cyc + 2;
        applyStimulus(0, t);
        sb_push(t + 10, SIG_A_CH,    0, "t4b_hold_end");
        sb_push(t + 11, SIG_A_CH,    1, "t4b_rel0");
        sb_push(t + 15, SIG_A_CH,    3, "t4b_rel1");
        sb_push(t + 21, SIG_A_CH,    3, "t4b_wait_ch");
        sb_push(t + 21, SIG_A_RETRY, 0, "t4b_wait_retry");
        sb_push(t + 21, SIG_A_BUSY,  1, "t4b_wait_busy");
        sb_push(t + 31, SIG_A_CH,    0, "t4b_timeout_ch");
        sb_push(t + 31, SIG_A_RETRY, 1, "t4b_timeout_retry");
        applyStimulus(0, t + 5);
        applyStimulus(0, t + 13);
        applyStimulus(0, t + 20);
        wait_drain(200);

        // Link never comes up: four attempts then FAIL.
        do_reset();
        t = cyc + 2;
        applyStimulus(0, t);
        for (int k = 0; k < 4; k++) begin
            b = t + 31 * k;
            sb_push(b + 1,  SIG_A_CH,    0, "t2_hold_start");
            sb_push(b + 1,  SIG_A_RETRY, k, "t2_retry");
            sb_push(b + 10, SIG_A_CH,    0, "t2_hold_end");
            sb_push(b + 11, SIG_A_CH,    1, "t2_rel0");
            sb_push(b + 15, SIG_A_CH,    3, "t2_rel1");
            sb_push(b + 15, SIG_A_BUSY,  1, "t2_busy");
        end
        sb_push(t + 123, SIG_A_FAIL,  0, "t2_pre_fail");
        sb_push(t + 124, SIG_A_FAIL,  1, "t2_fail");
        sb_push(t + 124, SIG_A_BUSY,  0, "t2_fail_busy");
        sb_push(t + 124, SIG_A_CH,    0, "t2_fail_ch");
        sb_push(t + 124, SIG_A_RETRY, 3, "t2_fail_retry");
        wait_drain(300);

        // Restart out of FAIL.
        t = cyc + 2;
        sb_push(t - 1,  SIG_A_FAIL,  1, "t6_in_fail");
        sb_push(t + 1,  SIG_A_FAIL,  0, "t6_fail_clr");
        sb_push(t + 1,  SIG_A_BUSY,  1, "t6_busy");
        sb_push(t + 1,  SIG_A_RETRY, 0, "t6_retry_clr");
        sb_push(t + 10, SIG_A_CH,    0, "t6_hold_end");
        sb_push(t + 11, SIG_A_CH,    1, "t6_rel0");
        sb_push(t + 16, SIG_A_DONE,  1, "t6_done");
        sb_push(t + 16, SIG_A_RETRY, 0, "t6_done_retry");
        applyStimulus(0, t);
        wait_edge(t + 12);
        bus_a.link_up = 2'b11;
        wait_drain(100);

        // Link lost in DONE triggers one retry, then recovers.
        do_reset();
        bus_a.link_up = 2'b11;
        t = cyc + 3;
        applyStimulus(0, t);
        sb_push(t + 15, SIG_A_DONE,  0, "t3_wait");
        sb_push(t + 15, SIG_A_CH,    3, "t3_rel1");
        sb_push(t + 16, SIG_A_DONE,  1, "t3_done");
        sb_push(t + 16, SIG_A_BUSY,  0, "t3_done_busy");
        sb_push(t + 16, SIG_A_RETRY, 0, "t3_done_retry");
        d = t + 20;
        sb_push(d + 2,  SIG_A_CH,    3, "t3_sync_lag_ch");
        sb_push(d + 2,  SIG_A_DONE,  1, "t3_sync_lag_done");
        sb_push(d + 3,  SIG_A_CH,    0, "t3_drop_ch");
        sb_push(d + 3,  SIG_A_RETRY, 1, "t3_drop_retry");
        sb_push(d + 3,  SIG_A_BUSY,  1, "t3_drop_busy");
        sb_push(d + 3,  SIG_A_DONE,  0, "t3_drop_done");
        sb_push(d + 13, SIG_A_CH,    0, "t3_re_hold_end");
        sb_push(d + 14, SIG_A_CH,    1, "t3_re_rel0");
        sb_push(d + 18, SIG_A_CH,    3, "t3_re_rel1");
        sb_push(d + 18, SIG_A_DONE,  0, "t3_re_wait");
        sb_push(d + 19, SIG_A_DONE,  1, "t3_re_done");
        sb_push(d + 19, SIG_A_RETRY, 1, "t3_re_retry");
        wait_edge(d);
        bus_a.link_up = 2'b01;
        wait_edge(d + 5);
        bus_a.link_up = 2'b11;
        wait_drain(100);

        // Four channels, stagger 1, link up exactly on the timeout edge.
        do_reset();
        t = cyc + 2;
        applyStimulus(1, t);
        sb_push(t + 10, SIG_B_CH,    4'h0, "t5_hold_end");
        sb_push(t + 11, SIG_B_CH,    4'h1, "t5_rel0");
        sb_push(t + 12, SIG_B_CH,    4'h3, "t5_rel1");
        sb_push(t + 13, SIG_B_CH,    4'h7, "t5_rel2");
        sb_push(t + 14, SIG_B_CH,    4'hF, "t5_rel3");
        sb_push(t + 14, SIG_B_BUSY,  1,    "t5_busy");
        sb_push(t + 29, SIG_B_DONE,  0,    "t5_pre_done");
        sb_push(t + 29, SIG_B_BUSY,  1,    "t5_pre_busy");
        sb_push(t + 30, SIG_B_DONE,  1,    "t5_done");
        sb_push(t + 30, SIG_B_BUSY,  0,    "t5_done_busy");
        sb_push(t + 30, SIG_B_RETRY, 0,    "t5_retry");
        sb_push(t + 30, SIG_B_CH,    4'hF, "t5_ch");
        wait_edge(t + 27);
        bus_b.link_up = 4'hF;
        wait_drain(100);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
